reg_file_arbiter: RTL and testbench
===================================

REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, data width of each register entry.
REQ-002 SHALL have parameter DEPTH, fixed at 4, number of entries; address width 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have ports req0/req1  input  1  access request from requester 0/1, held until granted.
REQ-006 SHALL have ports we0/we1  input  1  1=write, 0=read, qualified by reqN.
REQ-007 SHALL have ports addr0/addr1  input  2  target entry.
REQ-008 SHALL have ports wdata0/wdata1  input  DW  write data.
REQ-009 SHALL have port clear_n  input  1  active-low bank-clear command, synchronous.
REQ-010 SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse, registered.
REQ-011 SHALL have port rdata  output  DW  read result, registered.
REQ-012 SHALL have port rvalid  output  1  one-cycle qualifier for rdata.
REQ-013 SHALL have port busy  output  1  high while state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, CLEAR; encoding free.
REQ-015 SHALL, in IDLE with clear_n=0, enter CLEAR; clear_n beats any request.
REQ-016 SHALL, in IDLE with clear_n=1 and any reqN=1, capture winner's we/addr/wdata, enter ACCESS, assert winner's gnt for exactly the ACCESS cycle.
REQ-017 SHALL arbitrate round-robin: single requester always wins; on simultaneous req0&req1, grant the requester not granted last.
REQ-018 SHALL give requester 0 priority on the first contended arbitration after reset.
REQ-019 SHALL, for a write, update entry[addr] with captured wdata at the edge ending ACCESS.
REQ-020 SHALL, for a read, load rdata<=entry[addr] and pulse rvalid=1 in the cycle after ACCESS; rdata holds its value otherwise.
REQ-021 SHALL return from ACCESS to IDLE unconditionally; max throughput one access per 2 cycles.
REQ-022 SHALL never assert gnt0 and gnt1 together; gnt never asserts outside ACCESS.
REQ-023 SHALL, in CLEAR, zero entries 0,1,2,3 on 4 consecutive edges via internal 2-bit counter, then return to IDLE; busy=1 for 4 cycles.
REQ-024 SHALL ignore clear_n and reqN while in ACCESS or CLEAR; still-asserted inputs are evaluated on return to IDLE.
REQ-025 SHALL treat a reqN deasserted before its grant as withdrawn; no access performed.
REQ-026 SHALL not alter the round-robin pointer on CLEAR or idle cycles.

Reset
REQ-027 SHALL, on rising clk with reset_n=0: state IDLE, all entries 0, gnt0=gnt1=0, rvalid=0, rdata=0, busy=0, clear counter 0, round-robin to requester 0.
REQ-028 SHALL let reset_n=0 abort any ACCESS or CLEAR in progress; pending write not committed.
REQ-029 SHALL ignore reset_n changes between clock edges (no asynchronous effect).

Verification
REQ-030 Reset then req0=1,we0=1,addr0=2,wdata0=8'hA5 -> gnt0 one cycle later for 1 cycle; later read addr 2 gives rdata=8'hA5, rvalid one cycle after gnt.
REQ-031 req0 and req1 held together for 4 arbitrations -> grants alternate gnt0,gnt1,gnt0,gnt1, each 2 cycles apart, never overlapping.
REQ-032 Entries preloaded 11,22,33,44; clear_n=0 one cycle with req1 high -> busy 4 cycles, gnt1 only after, read of any entry returns 0.
REQ-033 reset_n=0 for one edge during ACCESS of write 8'hFF -> entry unchanged (0), outputs at reset values next cycle.
REQ-034 reset_n pulsed low between edges only (mid-cycle glitch not spanning an edge) -> no state change.
REQ-035 req1 asserted then dropped while state CLEAR -> no gnt1, no access.

Source files
------------

// File: rtl/reg_file_arbiter.sv
// Four-entry register file shared by two requesters through a round-robin arbiter.
// Each granted access takes one ACCESS cycle; a clear command zeroes the bank over four cycles.
`timescale 1ns/1ps
module reg_file_arbiter #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [1:0]    addr0,
  input  logic [1:0]    addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          clear_n,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CLEAR} state_e;

  state_e        r_state;
  state_e        w_nextState;
  logic          w_start;
  logic          w_winner;
  logic          r_lastGnt;
  logic [1:0]    r_clrCnt;
  logic          r_we;
  logic [1:0]    r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic          r_gnt0;
  logic          r_gnt1;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // r_lastGnt=1 after reset so requester 0 wins the first contended arbitration
  always_comb begin
    w_winner = 1'b0;
    if (req0 && req1) w_winner = ~r_lastGnt;
    else if (req1)    w_winner = 1'b1;
  end

  assign w_start = (r_state == IDLE) && clear_n && (req0 || req1);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (!clear_n)     w_nextState = CLEAR;
        else if (w_start) w_nextState = ACCESS;
      end
      ACCESS:  w_nextState = IDLE;
      CLEAR:   if (r_clrCnt == 2'd3) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_lastGnt <= 1'b1;
      r_clrCnt  <= 2'd0;
      r_we      <= 1'b0;
      r_addr    <= 2'd0;
      r_wdata   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_gnt0    <= ~w_winner;
            r_gnt1    <= w_winner;
            r_lastGnt <= w_winner;
            r_we      <= w_winner ? we1 : we0;
            r_addr    <= w_winner ? addr1 : addr0;
            r_wdata   <= w_winner ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          if (r_we) begin
            r_mem[r_addr] <= r_wdata;
          end else begin
            r_rdata  <= r_mem[r_addr];
            r_rvalid <= 1'b1;
          end
        end
        CLEAR: begin
          // counter wraps to 0 on the last entry, ready for the next clear
          r_mem[r_clrCnt] <= '0;
          r_clrCnt        <= r_clrCnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed self-checking bench for reg_file_arbiter: writes, reads, round-robin,
// bank clear, synchronous reset abort and mid-cycle reset glitch immunity.
`timescale 1ns/1ps
module tb_reg_file_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0, req1, we0, we1, clear_n;
  logic [1:0]    addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid, busy;
  logic [DW-1:0] rdata;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] preload [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  reg_file_arbiter #(.DW(DW), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .clear_n(clear_n),
    .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [1:0] addr, input logic [7:0] wdata);
    if (port == 0) begin
      req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doWrite(input int port, input logic [1:0] addr, input logic [7:0] data,
                         input string tag);
    applyStimulus(port, 1'b1, 1'b1, addr, data);
    tick();
    checkOutput({tag, "_gnt"}, {31'd0, (port == 0) ? gnt0 : gnt1}, 32'd1);
    applyStimulus(port, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
  endtask

  task automatic doRead(input int port, input logic [1:0] addr, input logic [7:0] expData,
                        input string tag);
    applyStimulus(port, 1'b1, 1'b0, addr, 8'h00);
    tick();
    checkOutput({tag, "_gnt"}, {31'd0, (port == 0) ? gnt0 : gnt1}, 32'd1);
    applyStimulus(port, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    checkOutput({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    checkOutput({tag, "_rdata"}, {24'd0, rdata}, {24'd0, expData});
  endtask

  initial begin
    reset_n = 1'b0; clear_n = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    tick();
    reset_n = 1'b1;
    checkOutput("rst_gnt0", {31'd0, gnt0}, 32'd0);
    checkOutput("rst_gnt1", {31'd0, gnt1}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("rst_rdata", {24'd0, rdata}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] write A5 to entry 2, read it back");
    applyStimulus(0, 1'b1, 1'b1, 2'd2, 8'hA5);
    tick();
    checkOutput("wr_gnt0", {31'd0, gnt0}, 32'd1);
    checkOutput("wr_gnt1", {31'd0, gnt1}, 32'd0);
    checkOutput("wr_busy", {31'd0, busy}, 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("wr_gnt0_end", {31'd0, gnt0}, 32'd0);
    checkOutput("wr_busy_end", {31'd0, busy}, 32'd0);
    checkOutput("wr_no_rvalid", {31'd0, rvalid}, 32'd0);
    doRead(1, 2'd2, 8'hA5, "rd_a5");
    tick();
    checkOutput("rd_rvalid_drop", {31'd0, rvalid}, 32'd0);
    checkOutput("rd_rdata_hold", {24'd0, rdata}, 32'h0000_00A5);

    $display("[TB] contended round-robin");
    applyStimulus(0, 1'b1, 1'b0, 2'd0, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 2'd3, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("rr%0d_gnt0", i), {31'd0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr%0d_gnt1", i), {31'd0, gnt1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      checkOutput($sformatf("rr%0d_gap", i), {30'd0, gnt0, gnt1}, 32'd0);
    end
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);

    $display("[TB] preload then clear with req1 pending");
    for (int i = 0; i < 4; i++) doWrite(0, 2'(i), preload[i], $sformatf("pre%0d", i));
    doRead(0, 2'd2, 8'h33, "pre_rd2");
    clear_n = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 2'd1, 8'h00);
    tick();
    clear_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("clr%0d_busy", i), {31'd0, busy}, 32'd1);
      checkOutput($sformatf("clr%0d_gnt1", i), {31'd0, gnt1}, 32'd0);
      tick();
    end
    checkOutput("clr_done_busy", {31'd0, busy}, 32'd0);
    checkOutput("clr_done_gnt1", {31'd0, gnt1}, 32'd0);
    tick();
    checkOutput("clr_after_gnt1", {31'd0, gnt1}, 32'd1);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("clr_rd1_rvalid", {31'd0, rvalid}, 32'd1);
    checkOutput("clr_rd1_rdata", {24'd0, rdata}, 32'd0);
    doRead(0, 2'd3, 8'h00, "clr_rd3");

    $display("[TB] reset aborts a pending write");
    doWrite(0, 2'd2, 8'h5C, "wr5c");
    doRead(0, 2'd2, 8'h5C, "rd5c");
    applyStimulus(0, 1'b1, 1'b1, 2'd0, 8'hFF);
    tick();
    checkOutput("abort_gnt0", {31'd0, gnt0}, 32'd1);
    reset_n = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    reset_n = 1'b1;
    checkOutput("abort_gnt0_rst", {31'd0, gnt0}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("abort_rdata", {24'd0, rdata}, 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 2'd0, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 2'd2, 8'h00);
    tick();
    checkOutput("first_contend_gnt0", {31'd0, gnt0}, 32'd1);
    checkOutput("first_contend_gnt1", {31'd0, gnt1}, 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("abort_entry0", {24'd0, rdata}, 32'd0);
    tick();
    checkOutput("pending_gnt1", {31'd0, gnt1}, 32'd1);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("rst_entry2", {24'd0, rdata}, 32'd0);

    $display("[TB] mid-cycle reset glitch");
    doWrite(0, 2'd1, 8'h77, "wr77");
    doRead(0, 2'd1, 8'h77, "rd77");
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    checkOutput("glitch_rdata", {24'd0, rdata}, 32'h0000_0077);
    checkOutput("glitch_busy", {31'd0, busy}, 32'd0);
    doRead(1, 2'd1, 8'h77, "glitch_rd");

    $display("[TB] request withdrawn during clear");
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    applyStimulus(1, 1'b1, 1'b1, 2'd1, 8'hEE);
    tick();
    checkOutput("wd_gnt1_a", {31'd0, gnt1}, 32'd0);
    tick();
    checkOutput("wd_gnt1_b", {31'd0, gnt1}, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("wd_gnt1_%0d", i), {31'd0, gnt1}, 32'd0);
    end
    checkOutput("wd_busy", {31'd0, busy}, 32'd0);
    doRead(0, 2'd1, 8'h00, "wd_rd1");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
